// File: rtl/poly_mod_add_stream.sv
// ---------------------------------------------------------------------------
// poly_mod_add_stream
//
// Streaming modular adder for polynomial coefficients, modulus q = 3329.
// Each accepted pair (a, b) produces o = (a + b) mod 3329 after a three-stage
// pipeline with full valid/ready back-pressure. Inputs may be non-canonical
// (any WIDTH-bit value), so the raw sum can reach 2*(2^WIDTH-1); two
// conditional subtractions bring the 12-bit worst case 8190 down to 1532.
// A coefficient counter frames the output stream into polynomials of N_COEF
// coefficients and raises out_last on the final one.
//
// Parameters
//   WIDTH      coefficient width in bits (default 12)
//   N_COEF     coefficients per polynomial (default 256)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   a, b       in   addend coefficients
//   in_valid   in   a/b valid
//   in_ready   out  block accepts a/b this cycle
//   o          out  (a + b) mod 3329
//   out_valid  out  o valid
//   out_ready  in   consumer accepts o this cycle
//   out_last   out  o is the final coefficient of the current polynomial
//   err        out  sticky out-of-range input flag
//
// Build option
//   POLY_MOD_ADD_RANGE_CHECK_EN  when defined, err sets on any accepted input
//   with a >= 3329 or b >= 3329 and stays set until reset. When undefined,
//   err is tied low and no comparators are built.
// ---------------------------------------------------------------------------
module poly_mod_add_stream #(
  parameter int WIDTH  = 12,
  parameter int N_COEF = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             err
);

  // Two guard bits hold the raw sum without overflow.
  localparam int SW = WIDTH + 2;
  localparam int CW = (N_COEF > 1) ? $clog2(N_COEF) : 1;

  localparam logic [SW-1:0] Q        = SW'(3329);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_COEF - 1);

  function automatic logic [SW-1:0] cond_sub(input logic [SW-1:0] v);
    return (v >= Q) ? (v - Q) : v;
  endfunction

  // Pipeline registers
  logic [SW-1:0] s1_q, s2_q, s3_q;
  logic [SW-1:0] s1_d, s2_d, s3_d;
  logic          v1_q, v2_q, v3_q;

  // Stage enables: a stage may load when it is empty or its contents leave
  // at the same edge. Chaining them from the output back gives full
  // throughput while stalled stages hold their data.
  logic en1, en2, en3;

  assign en3 = !v3_q || out_ready;
  assign en2 = !v2_q || en3;
  assign en1 = !v1_q || en2;

  assign s1_d = SW'(a) + SW'(b);
  assign s2_d = cond_sub(s1_q);
  assign s3_d = cond_sub(s2_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      if (en1) begin
        v1_q <= in_valid;
        // Data only moves with a valid token, so o stays quiet in idle gaps.
        if (in_valid) s1_q <= s1_d;
      end
      if (en2) begin
        v2_q <= v1_q;
        if (v1_q) s2_q <= s2_d;
      end
      if (en3) begin
        v3_q <= v2_q;
        if (v2_q) s3_q <= s3_d;
      end
    end
  end

  assign in_ready  = en1;
  assign out_valid = v3_q;
  assign o         = s3_q[WIDTH-1:0];

  // Coefficient counter for polynomial framing
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_xfer;

  assign out_xfer = v3_q && out_ready;
  assign out_last = v3_q && (cnt_q == LAST_IDX);

  always_comb begin
    cnt_d = cnt_q;
    if (out_xfer) begin
      cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef POLY_MOD_ADD_RANGE_CHECK_EN
  // Range check only flags; the arithmetic path is unaffected.
  logic err_q, err_d;
  logic in_xfer;
  logic range_bad;

  assign in_xfer   = in_valid && en1;
  assign range_bad = (SW'(a) >= Q) || (SW'(b) >= Q);
  assign err_d     = err_q || (in_xfer && range_bad);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_poly_mod_add_stream.sv
// ---------------------------------------------------------------------------
// tb_poly_mod_add_stream
//
// Directed bench for poly_mod_add_stream. A reference queue holds the
// expected (a + b) % 3329 for every accepted pair; a negedge monitor checks
// each valid output against it, tracks the polynomial index to predict
// out_last, predicts the sticky err flag and checks that outputs hold during
// stalls. Directed sequences add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_poly_mod_add_stream;

  localparam int WIDTH  = 12;
  localparam int N_COEF = 256;
  localparam int QMOD   = 3329;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a, b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] o;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             err;

  poly_mod_add_stream #(.WIDTH(WIDTH), .N_COEF(N_COEF)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .o         (o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model state
  int exp_q[$];
  int model_idx   = 0;
  bit model_err   = 1'b0;
  bit after_rst   = 1'b0;
  bit stall_prev  = 1'b0;
  int prev_o      = 0;
  bit prev_last   = 1'b0;
  int n_out       = 0;
  int n_last      = 0;
  int last_o      = -1;

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_idx  = 0;
      model_err  = 1'b0;
      after_rst  = 1'b1;
      stall_prev = 1'b0;
    end else begin
      if (after_rst) begin
        check(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
        check(out_last == 1'b0, "rst_out_last", int'(out_last), 0);
        check(o == '0, "rst_o", int'(o), 0);
        check(in_ready == 1'b1, "rst_in_ready", int'(in_ready), 1);
        after_rst = 1'b0;
      end
      check(err == model_err, "err", int'(err), int'(model_err));
      if (stall_prev) begin
        check(out_valid == 1'b1, "stall_valid", int'(out_valid), 1);
        check(int'(o) == prev_o, "stall_o", int'(o), prev_o);
        check(out_last == prev_last, "stall_last", int'(out_last), int'(prev_last));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_output", int'(o), -1);
        end else begin
          check(int'(o) == exp_q[0], "o", int'(o), exp_q[0]);
          check(out_last == (model_idx == N_COEF - 1), "out_last",
                int'(out_last), int'(model_idx == N_COEF - 1));
          if (out_ready) begin
            $display("out #%0d idx=%0d o=%0d last=%0d", n_out, model_idx, o, out_last);
            void'(exp_q.pop_front());
            n_out++;
            if (out_last) begin
              n_last++;
              last_o = int'(o);
            end
            model_idx = (model_idx == N_COEF - 1) ? 0 : model_idx + 1;
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_o     = int'(o);
      prev_last  = out_last;
      if (in_valid && in_ready) begin
        exp_q.push_back((int'(a) + int'(b)) % QMOD);
`ifdef POLY_MOD_ADD_RANGE_CHECK_EN
        if (int'(a) >= QMOD || int'(b) >= QMOD) model_err = 1'b1;
`endif
      end
    end
  end

  // Optional out_ready pattern 1,0,0,... driven just after each rising edge.
  bit pat_mode = 1'b0;
  int pat_cnt  = 0;
  always @(posedge clk) begin
    #1;
    if (pat_mode) begin
      out_ready = (pat_cnt % 3 == 0);
      pat_cnt++;
    end
  end

  // ------------------------------------------------------------ drivers
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int av, input int bv);
    bit ok;
    bit done;
    a = WIDTH'(av);
    b = WIDTH'(bv);
    in_valid = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) check(1'b0, "send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) check(1'b0, "drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Send one pair and check the first output that appears against a literal.
  task automatic send_literal(input int av, input int bv, input int exp_o, input string name);
    bit seen;
    send(av, bv);
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        check(int'(o) == exp_o, name, int'(o), exp_o);
      end
    end
    if (!seen) check(1'b0, {name, "_timeout"}, 0, 1);
    drain();
  endtask

  initial begin
    int base;
    rst       = 1'b1;
    a         = '0;
    b         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Latency: transfer at edge N, visible after edge N+2.
    send(3328, 1);
    @(negedge clk);
    check(out_valid == 1'b0, "lat_n", int'(out_valid), 0);
    @(negedge clk);
    check(out_valid == 1'b0, "lat_n1", int'(out_valid), 0);
    @(negedge clk);
    check(out_valid == 1'b1, "lat_n2_valid", int'(out_valid), 1);
    check(o == '0, "lat_n2_o", int'(o), 0);
    drain();

    // Worst-case and largest canonical results.
    send_literal(4095, 4095, 1532, "max_sum");
    send_literal(1664, 1664, 3328, "canon_max");
    send_literal(2000, 2000, 671, "one_sub");

    // Back-pressure: 10 pairs with out_ready toggling 1,0,0.
    base = n_out;
    pat_cnt  = 0;
    pat_mode = 1'b1;
    for (int i = 0; i < 10; i++) send(300 * i + 7, 4095 - 400 * i);
    drain();
    pat_mode  = 1'b0;
    out_ready = 1'b1;
    check(n_out - base == 10, "stall_count", n_out - base, 10);

    // Framing: 257 pairs, a=i, b=0, counter starting from 0.
    do_reset();
    n_last = 0;
    last_o = -1;
    for (int i = 0; i < 257; i++) send(i, 0);
    drain();
    check(n_last == 1, "last_count", n_last, 1);
    check(last_o == 255, "last_o", last_o, 255);
    check(model_idx == 1, "idx_after_wrap", model_idx, 1);

    // Reset with three pairs in flight, then a fresh pair.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(100 + i, 1);
    do_reset();
    out_ready = 1'b1;
    check(exp_q.size() == 0, "flush_queue", exp_q.size(), 0);
    send_literal(5, 7, 12, "after_rst");
    check(model_idx == 1, "idx_restart", model_idx, 1);

    // Out-of-range input: arithmetic unaffected; err tracked by the monitor.
    send_literal(3329, 0, 0, "range_o");
    repeat (3) @(negedge clk);
`ifdef POLY_MOD_ADD_RANGE_CHECK_EN
    check(err == 1'b1, "err_sticky", int'(err), 1);
`else
    check(err == 1'b0, "err_tied", int'(err), 0);
`endif
    do_reset();
    @(negedge clk);
    check(err == 1'b0, "err_cleared", int'(err), 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
